// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one 32-bit shift datapath (logical-left shifter plus a 5-stage
//   arithmetic-right barrel shifter) between two requesters: requester 0 is
//   the ALU issue path, requester 1 is the mult/div sequencer. One operation
//   is in flight at a time; the result is registered and returned through a
//   valid/ready response handshake.
//
// Parameters
//   RR_ENABLE  1 = round-robin grant on contention, 0 = requester 0 always wins
//
// Ports
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   reqN_valid/ready                 command handshake for requester N (ready is
//                                    combinational, only asserted in IDLE)
//   reqN_data/shamt/op               operand, shift amount, 0 = sll / 1 = sra
//   resp_valid/ready/id/data         registered result and its owner
//   busy                             an operation is in BUSY or DONE
module shift_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_op,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    input  logic        resp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rr_ptr;
    logic        grant_id;
    logic        accept;
    logic [31:0] lat_data;
    logic [4:0]  lat_shamt;
    logic        lat_op;
    logic        lat_id;

    logic [31:0] sra_16;
    logic [31:0] sra_8;
    logic [31:0] sra_4;
    logic [31:0] sra_2;
    logic [31:0] sra_1;
    logic [31:0] sll_result;
    logic [31:0] shift_result;

    // Grant and next-state. Ready is withheld during reset so nothing is
    // reported as accepted on an edge that reset discards.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (req0_valid && req1_valid) begin
                        grant_id = RR_ENABLE ? rr_ptr : 1'b0;
                    end else begin
                        grant_id = req1_valid;
                    end
                    req0_ready = req0_valid && !grant_id;
                    req1_ready = req1_valid && grant_id;
                    if (req0_ready || req1_ready) begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: state_next = DONE;
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req0_ready || req1_ready;

    // Arithmetic-right barrel shifter: 16/8/4/2/1 mux chain, sign filled.
    assign sra_16 = lat_shamt[4] ? {{16{lat_data[31]}}, lat_data[31:16]} : lat_data;
    assign sra_8  = lat_shamt[3] ? {{8{sra_16[31]}}, sra_16[31:8]} : sra_16;
    assign sra_4  = lat_shamt[2] ? {{4{sra_8[31]}}, sra_8[31:4]} : sra_8;
    assign sra_2  = lat_shamt[1] ? {{2{sra_4[31]}}, sra_4[31:2]} : sra_4;
    assign sra_1  = lat_shamt[0] ? {sra_2[31], sra_2[31:1]} : sra_2;

    assign sll_result   = lat_data << lat_shamt;
    assign shift_result = lat_op ? sra_1 : sll_result;

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            lat_data   <= '0;
            lat_shamt  <= '0;
            lat_op     <= 1'b0;
            lat_id     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_data  <= req1_ready ? req1_data  : req0_data;
                lat_shamt <= req1_ready ? req1_shamt : req0_shamt;
                lat_op    <= req1_ready ? req1_op    : req0_op;
                lat_id    <= req1_ready;
                rr_ptr    <= !req1_ready;
            end
            if (state == BUSY) begin
                resp_data  <= shift_result;
                resp_id    <= lat_id;
                resp_valid <= 1'b1;
            end else if (state == DONE && resp_ready) begin
                // resp_data/resp_id intentionally keep their last value
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
//   Scoreboard bench for shift_arbiter. Command queues feed two requester
//   drivers; a monitor checks grants against the arbitration rules, pushes the
//   reference shift result on every accept and pops/compares whenever the
//   arbiter presents a response. A second instance with RR_ENABLE = 0 and
//   both requesters permanently valid checks fixed priority.
module tb_shift_arbiter;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        bit          op;
    } cmd_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        resp_valid, resp_id, resp_ready, busy;
    logic [31:0] resp_data;

    logic        f_req0_valid, f_req0_ready, f_req0_op;
    logic [31:0] f_req0_data;
    logic [4:0]  f_req0_shamt;
    logic        f_req1_valid, f_req1_ready, f_req1_op;
    logic [31:0] f_req1_data;
    logic [4:0]  f_req1_shamt;
    logic        f_resp_valid, f_resp_id, f_busy;
    logic [31:0] f_resp_data;
    logic        f_resp_ready;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    cmd_t cmdq0[$];
    cmd_t cmdq1[$];
    exp_t sbq[$];
    bit   armed = 1'b0;
    bit   gap_en = 1'b0;
    bit   rand_ready = 1'b0;
    bit   tp_mode = 1'b0;
    int   tp_last = -1;
    bit   pending = 1'b0;
    bit   rr_model = 1'b0;
    bit   seen = 1'b0;
    int   f_acc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    shift_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready), .busy(busy)
    );

    shift_arbiter #(.RR_ENABLE(1'b0)) u_fix (
        .clock(clock), .reset(reset),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_data(f_req0_data),
        .req0_shamt(f_req0_shamt), .req0_op(f_req0_op),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_data(f_req1_data),
        .req1_shamt(f_req1_shamt), .req1_op(f_req1_op),
        .resp_valid(f_resp_valid), .resp_id(f_resp_id), .resp_data(f_resp_data),
        .resp_ready(f_resp_ready), .busy(f_busy)
    );

    // Reference shift: sll zero-fills, sra replicates the sign bit.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input bit op);
        logic signed [31:0] sd;
        sd = d;
        if (op) return sd >>> s;
        return d << s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input logic [31:0] d, input logic [4:0] s, input bit op);
        cmd_t c;
        c.data = d; c.shamt = s; c.op = op;
        cmdq0.push_back(c);
    endtask

    task automatic push1(input logic [31:0] d, input logic [4:0] s, input bit op);
        cmd_t c;
        c.data = d; c.shamt = s; c.op = op;
        cmdq1.push_back(c);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.data  = $urandom();
        c.shamt = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0)
                                              : 5'($urandom_range(0, 31));
        c.op    = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Requester drivers: hold valid and operands until accepted.
    initial begin : drv0
        bit   taken;
        cmd_t c;
        req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = 1'b0;
        forever begin
            @(negedge clock);
            taken = req0_valid && req0_ready;
            @(posedge clock); #1;
            if (taken) req0_valid = 1'b0;
            if (!req0_valid && cmdq0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                c = cmdq0.pop_front();
                req0_data = c.data; req0_shamt = c.shamt; req0_op = c.op;
                req0_valid = 1'b1;
            end
        end
    end

    initial begin : drv1
        bit   taken;
        cmd_t c;
        req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = 1'b0;
        forever begin
            @(negedge clock);
            taken = req1_valid && req1_ready;
            @(posedge clock); #1;
            if (taken) req1_valid = 1'b0;
            if (!req1_valid && cmdq1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                c = cmdq1.pop_front();
                req1_data = c.data; req1_shamt = c.shamt; req1_op = c.op;
                req1_valid = 1'b1;
            end
        end
    end

    initial begin : rdy_drv
        resp_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (rand_ready) resp_ready = 1'b1 & 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard for the round-robin instance.
    always @(negedge clock) begin
        logic [1:0] exp_rdy;
        exp_t       e;
        bit         id;
        if (armed) begin
            if (reset) begin
                chk("ready_in_reset", 32'({req1_ready, req0_ready}), 32'd0);
                sbq.delete();
                pending  = 1'b0;
                rr_model = 1'b0;
                seen     = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(pending));
                exp_rdy = 2'b00;
                if (!pending) begin
                    if (req0_valid && req1_valid) exp_rdy = rr_model ? 2'b10 : 2'b01;
                    else if (req0_valid)          exp_rdy = 2'b01;
                    else if (req1_valid)          exp_rdy = 2'b10;
                end
                chk("grant", 32'({req1_ready, req0_ready}), 32'(exp_rdy));

                if (resp_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_resp: got resp_valid=1 id=%0d data=%0h expected no response (cycle %0d)",
                                 resp_id, resp_data, cyc);
                    end else begin
                        e = sbq[0];
                        chk("resp_id", 32'(resp_id), 32'(e.id));
                        chk("resp_data", resp_data, e.data);
                        if (!seen) begin
                            chk("latency", 32'(cyc), 32'(e.acc + 2));
                            seen = 1'b1;
                        end
                        if (resp_ready) begin
                            void'(sbq.pop_front());
                            seen    = 1'b0;
                            pending = 1'b0;
                        end
                    end
                end

                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    id     = req1_valid && req1_ready;
                    e.id   = id;
                    e.data = id ? ref_shift(req1_data, req1_shamt, req1_op)
                                : ref_shift(req0_data, req0_shamt, req0_op);
                    e.acc  = cyc;
                    sbq.push_back(e);
                    pending  = 1'b1;
                    rr_model = !id;
                    if (tp_mode) begin
                        if (tp_last >= 0) chk("throughput", 32'(cyc - tp_last), 32'd3);
                        tp_last = cyc;
                    end
                end
            end
        end
    end

    // Fixed-priority instance: requester 1 must never win.
    always @(negedge clock) begin
        if (armed && !reset) begin
            chk("fix_req1_ready", 32'(f_req1_ready), 32'd0);
            if (f_req0_ready) f_acc++;
            if (f_resp_valid) begin
                chk("fix_resp_id", 32'(f_resp_id), 32'd0);
                chk("fix_resp_data", f_resp_data, ref_shift(f_req0_data, f_req0_shamt, f_req0_op));
            end
        end
    end

    always @(posedge clock) begin
        if (cyc > 50000) begin
            errors++;
            $display("FAIL watchdog: got cycle %0d expected completion before 50000", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        repeat (3) @(posedge clock);
        while ((cmdq0.size() > 0 || cmdq1.size() > 0 || req0_valid || req1_valid ||
                pending || sbq.size() > 0) && n < limit) begin
            @(posedge clock);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0 within %0d cycles",
                     sbq.size() + cmdq0.size() + cmdq1.size(), limit);
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin : main
        int n;
        reset = 1'b1;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1; f_resp_ready = 1'b1;
        f_req0_data  = $urandom(); f_req0_shamt = 5'($urandom_range(0, 31)); f_req0_op = 1'b1;
        f_req1_data  = $urandom(); f_req1_shamt = 5'($urandom_range(0, 31)); f_req1_op = 1'b0;

        @(posedge clock); #1;
        armed = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        @(negedge clock);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_id", 32'(resp_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single sra, then sll edge, then pass-through with both ops.
        push0(32'h8000_0000, 5'd4, 1'b1);
        wait_idle(50);
        @(negedge clock);
        chk("hold_sra", resp_data, 32'hF800_0000);
        push1(32'h0000_0001, 5'd31, 1'b0);
        wait_idle(50);
        @(negedge clock);
        chk("hold_sll", resp_data, 32'h8000_0000);
        push0(32'h1234_5678, 5'd0, 1'b0);
        push0(32'h1234_5678, 5'd0, 1'b1);
        wait_idle(50);
        @(negedge clock);
        chk("hold_pass", resp_data, 32'h1234_5678);

        // Contention from reset: grants alternate starting with requester 0.
        pulse_reset();
        push0(32'hF000_0000, 5'd8, 1'b1);
        push1(32'h0000_FFFF, 5'd16, 1'b0);
        push0(32'h0F0F_0F0F, 5'd3, 1'b1);
        push1(32'h8421_8421, 5'd5, 1'b0);
        wait_idle(100);

        // Backpressure: requester 1 waits through a held DONE.
        @(posedge clock); #1;
        resp_ready = 1'b0;
        push0(32'hA5A5_A5A5, 5'd7, 1'b1);
        push1(32'h0000_0003, 5'd30, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clock);
            n++;
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        resp_ready = 1'b1;
        wait_idle(50);

        // Reset while BUSY: operation discarded, pointer back to 0.
        push0(32'hDEAD_BEEF, 5'd12, 1'b1);
        n = 0;
        @(negedge clock);
        while (!(req0_valid && req0_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("rb_accept_seen", 32'(req0_ready), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("rb_no_resp", 32'(resp_valid), 32'd0);
        end
        push1(32'h0000_00F0, 5'd4, 1'b0);
        push0(32'hFFFF_0000, 5'd16, 1'b1);
        wait_idle(50);

        // Throughput: back-to-back requester 0 stream.
        tp_mode = 1'b1;
        tp_last = -1;
        repeat (6) cmdq0.push_back(rand_cmd());
        wait_idle(100);
        tp_mode = 1'b0;

        // Randomised traffic with gaps and random backpressure.
        gap_en = 1'b1;
        rand_ready = 1'b1;
        repeat (40) begin
            cmdq0.push_back(rand_cmd());
            cmdq1.push_back(rand_cmd());
        end
        wait_idle(3000);
        rand_ready = 1'b0;
        gap_en = 1'b0;
        @(posedge clock); #1;
        resp_ready = 1'b1;
        wait_idle(50);

        checks++;
        if (f_acc < 10) begin
            errors++;
            $display("FAIL fix_progress: got %0d accepts expected at least 10", f_acc);
        end
        chk("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath between two requesters: requester 0 is the ALU issue path, requester 1 is the mult/div sequencer.
- The shift datapath is a logical-left shifter plus an arithmetic-right 5-stage barrel shifter (16/8/4/2/1 mux chain).
- Round-robin arbitration, one operation in flight, registered result with valid/ready response handshake.
- Sits between the execute-stage requesters and the shifter instances.

Parameters:
- RR_ENABLE, 1, 1 = round-robin grant; 0 = fixed priority, requester 0 always wins.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a command
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_data  input  32  requester 0 operand
- req0_shamt  input  5  requester 0 shift amount
- req0_op  input  1  0 = sll, 1 = sra
- req1_valid  input  1  requester 1 has a command
- req1_ready  output  1  requester 1 command accepted this cycle
- req1_data  input  32  requester 1 operand
- req1_shamt  input  5  requester 1 shift amount
- req1_op  input  1  0 = sll, 1 = sra
- resp_valid  output  1  result available
- resp_id  output  1  requester that owns resp_data
- resp_data  output  32  shift result
- resp_ready  input  1  owner consumes result
- busy  output  1  state is not IDLE

Behaviour:
- Reset (synchronous, wins over everything):
  - state = IDLE, rr_ptr = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0.
  - req0_ready = req1_ready = 0.
  - Latched operand registers cleared.
- State IDLE:
  - reqN_ready is combinational and is high only for the granted requester with reqN_valid = 1.
  - At most one ready is high per cycle. Both ready are low in every other state.
- Grant rules in IDLE:
  - Only one valid: grant that requester.
  - Both valid, RR_ENABLE = 1: grant requester rr_ptr.
  - Both valid, RR_ENABLE = 0: grant requester 0.
  - Neither valid: stay IDLE, no grant.
- Accept edge (valid & ready):
  - Latch data, shamt, op and id.
  - rr_ptr <= ~id; rr_ptr is updated only on an accept.
  - state <= BUSY.
- State BUSY (exactly 1 cycle):
  - Shifter evaluates the latched operands.
  - At the end of the cycle: resp_data <= shifted result, resp_id <= latched id, resp_valid <= 1, state <= DONE.
- State DONE:
  - resp_valid = 1; resp_data and resp_id are held stable while resp_ready = 0, with no limit.
  - Edge with resp_ready = 1: resp_valid <= 0, state <= IDLE. resp_data keeps its last value.
- Latency:
  - Accept at edge N; resp_valid high from cycle N+2.
  - Earliest next accept is the cycle after the DONE handshake.
  - Throughput is 1 operation per 3 cycles with resp_ready tied high.
- Arithmetic:
  - sll fills with zeros.
  - sra replicates bit 31.
  - shamt = 0 passes data through unchanged.
  - shamt is taken mod 32 by its width; there is no overflow flag.
- busy = 1 in BUSY and DONE.
- Requester obligations:
  - Hold valid and operands stable until ready.
  - A requester that drops valid before grant is never serviced.
  - Arbiter behaviour is undefined if operands change while valid = 1 and ready = 0.
- reset mid-operation (BUSY or DONE): the operation is discarded, no response is issued, rr_ptr returns to 0.
- Requesting while waiting in DONE: valid held high in DONE is not accepted and not lost. It is arbitrated in the following IDLE cycle.

Test Plan:
- Single sra, RR=1: req0 data 0x80000000, shamt 4, op 1 -> req0_ready at accept cycle; resp_valid at N+2; resp_data 0xF8000000; resp_id 0.
- sll edge: req1 data 0x00000001, shamt 31, op 0 -> resp_data 0x80000000, resp_id 1. Pass-through: 0x12345678, shamt 0, either op -> 0x12345678.
- Contention, RR=1, both valid from reset: req0 0xF0000000 sra 8; req1 0x0000FFFF sll 16 -> first resp id 0 = 0xFFF00000; second resp id 1 = 0xFFFF0000; a third simultaneous pair grants id 0 again. Repeat with RR=0 and req0 always valid -> req1 never granted.
- Backpressure: resp_ready low for 3 cycles in DONE, with req1 valid throughout -> resp_valid, resp_data and resp_id stable; req1_ready stays 0; req1 accepted in the IDLE cycle after the handshake.
- Reset in BUSY: assert reset for 1 cycle at N+1 -> no resp_valid ever; busy = 0 the next cycle; next request with both valid goes to requester 0.
- Throughput: back-to-back req0 stream with resp_ready = 1 -> one accept every 3 cycles; results match a reference shift per operand.
